// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, selectable read latency and
// read-during-write mode, deterministic write collisions and a clear sequencer.
module dual_port_ram_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE         = 1024,
  parameter int ADDR_WIDTH   = $clog2(SIZE),
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_enable_in,
  input  logic                    a_wb_in,
  input  logic [DATA_WIDTH/8-1:0] a_be_in,
  input  logic [ADDR_WIDTH-1:0]   a_addr_in,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  input  logic                    b_enable_in,
  input  logic                    b_wb_in,
  input  logic [DATA_WIDTH/8-1:0] b_be_in,
  input  logic [ADDR_WIDTH-1:0]   b_addr_in,
  input  logic [DATA_WIDTH-1:0]   b_data_in,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  output logic                    ready_out,
  output logic                    collision_out,
  output logic [COUNT_WIDTH-1:0]  collision_count_out
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(SIZE - 1);

  localparam logic [ADDR_WIDTH:0] SIZE_W =
    (ADDR_WIDTH + 1)'(SIZE);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [ADDR_WIDTH-1:0]  clr_ptr_q;
  logic [ADDR_WIDTH-1:0]  clr_ptr_d;
  logic                   coll_q;
  logic                   coll_d;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;

  logic [DATA_WIDTH-1:0]  mem_q [SIZE];

  logic                   is_ready;
  logic                   a_in_rng;
  logic                   b_in_rng;
  logic                   a_we;
  logic                   b_we;
  logic                   coll;
  logic [DATA_WIDTH-1:0]  a_old;
  logic [DATA_WIDTH-1:0]  b_old;
  logic [DATA_WIDTH-1:0]  a_own;
  logic [DATA_WIDTH-1:0]  b_own;
  logic [DATA_WIDTH-1:0]  a_wr_word;

  // Overlay the enabled bytes of new_w onto old_w.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  // State, clear pointer and collision bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      coll_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      coll_q    <= coll_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: walk the clear pointer to the last word, then stay ready.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = S_READY;
          clr_ptr_d = '0;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    is_ready  = (state_q == S_READY);
    ready_out = is_ready;
  end

  // Request qualification, collision detection and write-word merging.
  always_comb begin
    a_in_rng  = ({1'b0, a_addr_in} < SIZE_W);
    b_in_rng  = ({1'b0, b_addr_in} < SIZE_W);
    a_old     = a_in_rng ? mem_q[a_addr_in] : '0;
    b_old     = b_in_rng ? mem_q[b_addr_in] : '0;
    a_we      = is_ready & a_enable_in & a_wb_in & a_in_rng;
    b_we      = is_ready & b_enable_in & b_wb_in & b_in_rng;
    coll      = a_we & b_we & (a_addr_in == b_addr_in);
    a_own     = merge(a_old, a_data_in, a_be_in);
    b_own     = merge(b_old, b_data_in, b_be_in);
    a_wr_word = coll ? merge(b_own, a_data_in, a_be_in) : a_own;
  end

  // Collision pulse and saturating counter.
  always_comb begin
    coll_d = coll;
    cnt_d  = cnt_q;
    if (coll && (cnt_q != '1)) begin
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign collision_out       = coll_q;
  assign collision_count_out = cnt_q;

  // Array writes: clear sweep, or port writes (A carries the merged word).
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (a_we) begin
          mem_q[a_addr_in] <= a_wr_word;
        end
        if (b_we && !coll) begin
          mem_q[b_addr_in] <= b_own;
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_rd

    // Combinational read of pre-edge contents; zero while clearing.
    always_comb begin
      a_data_out = is_ready ? a_old : '0;
      b_data_out = is_ready ? b_old : '0;
    end

  end else begin : g_reg_rd

    logic [DATA_WIDTH-1:0] a_rd_q;
    logic [DATA_WIDTH-1:0] a_rd_d;
    logic [DATA_WIDTH-1:0] b_rd_q;
    logic [DATA_WIDTH-1:0] b_rd_d;

    // Select old or own-merged word and load it on an enabled access.
    always_comb begin
      a_rd_d = a_rd_q;
      b_rd_d = b_rd_q;
      if (is_ready && a_enable_in) begin
        a_rd_d = ((RDW_MODE == 1) && a_we) ? a_own : a_old;
      end
      if (is_ready && b_enable_in) begin
        b_rd_d = ((RDW_MODE == 1) && b_we) ? b_own : b_old;
      end
    end

    // Registered read data.
    always_ff @(posedge clock) begin
      if (reset) begin
        a_rd_q <= '0;
        b_rd_q <= '0;
      end else begin
        a_rd_q <= a_rd_d;
        b_rd_q <= b_rd_d;
      end
    end

    assign a_data_out = a_rd_q;
    assign b_data_out = b_rd_q;

  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: three builds share one stimulus
// (registered read-first, registered write-first, combinational SIZE=12).
module tb_dual_port_ram_be;

  logic        clock;
  logic        reset;
  logic        a_en, a_wb, b_en, b_wb;
  logic [3:0]  a_be, b_be;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] d0_a, d0_b, d1_a, d1_b, d2_a, d2_b;
  logic        d0_rdy, d1_rdy, d2_rdy;
  logic        d0_col, d1_col, d2_col;
  logic [1:0]  d0_cnt;
  logic [15:0] d1_cnt, d2_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dual_port_ram_be #(
    .DATA_WIDTH(32), .SIZE(16), .READ_LATENCY(1),
    .RDW_MODE(0), .COUNT_WIDTH(2)
  ) d0 (
    .clock(clock), .reset(reset),
    .a_enable_in(a_en), .a_wb_in(a_wb), .a_be_in(a_be),
    .a_addr_in(a_addr), .a_data_in(a_din), .a_data_out(d0_a),
    .b_enable_in(b_en), .b_wb_in(b_wb), .b_be_in(b_be),
    .b_addr_in(b_addr), .b_data_in(b_din), .b_data_out(d0_b),
    .ready_out(d0_rdy), .collision_out(d0_col),
    .collision_count_out(d0_cnt)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(32), .SIZE(16), .READ_LATENCY(1),
    .RDW_MODE(1), .COUNT_WIDTH(16)
  ) d1 (
    .clock(clock), .reset(reset),
    .a_enable_in(a_en), .a_wb_in(a_wb), .a_be_in(a_be),
    .a_addr_in(a_addr), .a_data_in(a_din), .a_data_out(d1_a),
    .b_enable_in(b_en), .b_wb_in(b_wb), .b_be_in(b_be),
    .b_addr_in(b_addr), .b_data_in(b_din), .b_data_out(d1_b),
    .ready_out(d1_rdy), .collision_out(d1_col),
    .collision_count_out(d1_cnt)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(32), .SIZE(12), .READ_LATENCY(0),
    .RDW_MODE(0), .COUNT_WIDTH(16)
  ) d2 (
    .clock(clock), .reset(reset),
    .a_enable_in(a_en), .a_wb_in(a_wb), .a_be_in(a_be),
    .a_addr_in(a_addr), .a_data_in(a_din), .a_data_out(d2_a),
    .b_enable_in(b_en), .b_wb_in(b_wb), .b_be_in(b_be),
    .b_addr_in(b_addr), .b_data_in(b_din), .b_data_out(d2_b),
    .ready_out(d2_rdy), .collision_out(d2_col),
    .collision_count_out(d2_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_en = 0; a_wb = 0; a_be = 4'h0; a_addr = 4'h0; a_din = '0;
    b_en = 0; b_wb = 0; b_be = 4'h0; b_addr = 4'h0; b_din = '0;
  endtask

  task automatic wr_a(input logic [3:0] ad, input logic [31:0] d,
                      input logic [3:0] be);
    a_en = 1; a_wb = 1; a_addr = ad; a_din = d; a_be = be;
  endtask

  task automatic wr_b(input logic [3:0] ad, input logic [31:0] d,
                      input logic [3:0] be);
    b_en = 1; b_wb = 1; b_addr = ad; b_din = d; b_be = be;
  endtask

  task automatic rd_a(input logic [3:0] ad);
    a_en = 1; a_wb = 0; a_addr = ad; a_be = 4'h0;
  endtask

  task automatic rd_b(input logic [3:0] ad);
    b_en = 1; b_wb = 0; b_addr = ad; b_be = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    repeat (16) step();
    chk("init_ready_d0", 32'(d0_rdy), 32'd1);
    chk("init_ready_d2", 32'(d2_rdy), 32'd1);

    // fill with garbage through the front door
    for (int i = 0; i < 16; i++) begin
      wr_a(4'(i), 32'hA5A50000 | 32'(i), 4'hF);
      step();
    end
    idle();

    // reset pulse, then a 16-edge clear (12 for the small build)
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_ready", 32'(d0_rdy), 32'd0);
    chk("rst_coll", 32'(d0_col), 32'd0);
    chk("rst_cnt", 32'(d0_cnt), 32'd0);
    chk("rst_dout", d0_a, 32'd0);
    for (int e = 1; e <= 16; e++) begin
      if (e >= 5 && e <= 12) wr_a(4'd3, 32'hDEADBEEF, 4'hF);
      else idle();
      step();
      chk($sformatf("clr_rdy16_e%0d", e), 32'(d0_rdy), 32'(e == 16));
      chk($sformatf("clr_rdy12_e%0d", e), 32'(d2_rdy), 32'(e >= 12));
    end
    idle();

    // every address reads zero after the clear
    for (int i = 0; i < 16; i++) begin
      rd_a(4'(i));
      #1;
      chk($sformatf("clr_rd_d2_%0d", i), d2_a, 32'd0);
      step();
      chk($sformatf("clr_rd_d0_%0d", i), d0_a, 32'd0);
      chk($sformatf("clr_rd_d1_%0d", i), d1_a, 32'd0);
    end
    idle();

    // byte enables
    wr_a(4'd5, 32'hAABBCCDD, 4'hF);
    step();
    wr_a(4'd5, 32'h11223344, 4'b0101);
    step();
    chk("be_rdw0", d0_a, 32'hAABBCCDD);
    chk("be_rdw1", d1_a, 32'hAA22CC44);
    wr_a(4'd5, 32'hFFFFFFFF, 4'h0);
    step();
    chk("be0_rdw0", d0_a, 32'hAA22CC44);
    chk("be0_rdw1", d1_a, 32'hAA22CC44);
    rd_a(4'd5);
    #1;
    chk("be_rd_comb", d2_a, 32'hAA22CC44);
    step();
    chk("be_rd_reg", d0_a, 32'hAA22CC44);
    idle();
    step();
    chk("hold_en0", d0_a, 32'hAA22CC44);

    // collision on addr 7
    wr_a(4'd7, 32'h11111111, 4'b0011);
    wr_b(4'd7, 32'h22222222, 4'b1110);
    step();
    chk("col_pulse_d0", 32'(d0_col), 32'd1);
    chk("col_pulse_d2", 32'(d2_col), 32'd1);
    chk("col_cnt_d0", 32'(d0_cnt), 32'd1);
    chk("col_cnt_d1", 32'(d1_cnt), 32'd1);
    idle();
    step();
    chk("col_pulse_end", 32'(d0_col), 32'd0);
    rd_a(4'd7);
    #1;
    chk("col_word_d2", d2_a, 32'h22221111);
    step();
    chk("col_word_d0", d0_a, 32'h22221111);
    chk("col_word_d1", d1_a, 32'h22221111);
    wr_a(4'd7, 32'h11111111, 4'b0011);
    wr_b(4'd7, 32'h22222222, 4'b1110);
    repeat (4) step();
    chk("sat_cnt_d0", 32'(d0_cnt), 32'd3);
    chk("sat_cnt_d1", 32'(d1_cnt), 32'd5);
    chk("sat_cnt_d2", 32'(d2_cnt), 32'd5);

    // read plus write on the same address is no collision
    idle();
    wr_a(4'd7, 32'h0BADF00D, 4'hF);
    rd_b(4'd7);
    step();
    chk("rw_nocol", 32'(d0_col), 32'd0);
    chk("rw_nocnt", 32'(d1_cnt), 32'd5);
    chk("rw_old_d0", d0_b, 32'h22221111);
    chk("rw_old_d1", d1_b, 32'h22221111);
    idle();

    // read-during-write on addr 9 (zero)
    wr_a(4'd9, 32'hCAFEBABE, 4'hF);
    rd_b(4'd9);
    #1;
    chk("rdw_b_comb", d2_b, 32'd0);
    step();
    chk("rdw_a_rf", d0_a, 32'd0);
    chk("rdw_a_wf", d1_a, 32'hCAFEBABE);
    chk("rdw_b_rf", d0_b, 32'd0);
    chk("rdw_b_wf", d1_b, 32'd0);
    idle();

    // combinational read, same cycle as the request
    wr_a(4'd4, 32'h12345678, 4'hF);
    step();
    rd_a(4'd4);
    #1;
    chk("lat0_rd", d2_a, 32'h12345678);
    step();
    idle();

    // addr 13 is out of range only for the SIZE=12 build
    wr_a(4'd13, 32'h55555555, 4'hF);
    wr_b(4'd13, 32'h66666666, 4'hF);
    step();
    chk("oor_nocol_d2", 32'(d2_col), 32'd0);
    chk("oor_cnt_d2", 32'(d2_cnt), 32'd5);
    chk("inr_col_d1", 32'(d1_col), 32'd1);
    chk("inr_cnt_d1", 32'(d1_cnt), 32'd6);
    idle();
    rd_a(4'd13);
    #1;
    chk("oor_rd_d2", d2_a, 32'd0);
    step();
    chk("inr_rd_d0", d0_a, 32'h55555555);
    idle();

    // reset restarted midway through the clear
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_cnt", 32'(d1_cnt), 32'd0);
    chk("rst2_dout", d0_a, 32'd0);
    repeat (8) step();
    chk("mid_rdy", 32'(d0_rdy), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk($sformatf("rclr_rdy_e%0d", e), 32'(d1_rdy), 32'(e == 16));
    end
    rd_a(4'd5);
    step();
    chk("rclr_zero", d0_a, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Next-generation true dual-port RAM for the packet simulator's memory subsystem.
- Both ports read and write independently, with per-byte write enables.
- Read latency is selectable, and read-during-write behaviour on the same port is selectable.
- Same-address write collisions resolve deterministically and are reported.
- A hardware clear sequencer zeroes the whole array after every reset, so no initial block is needed.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; BE_WIDTH = DATA_WIDTH/8.
SIZE, 1024, number of words; need not be a power of two.
ADDR_WIDTH, $clog2(SIZE), address width in bits.
READ_LATENCY, 1, 0 = combinational read; 1 = registered read.
RDW_MODE, 0, same-port read-during-write with READ_LATENCY=1: 0 = read-first (old data), 1 = write-first (merged new data).
COUNT_WIDTH, 16, width of the collision counter.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
a_enable_in  in  1  port A access request.
a_wb_in  in  1  port A write (1) / read (0).
a_be_in  in  BE_WIDTH  port A byte write enables; bit i covers data bits [8i+7:8i].
a_addr_in  in  ADDR_WIDTH  port A word address.
a_data_in  in  DATA_WIDTH  port A write data.
a_data_out  out  DATA_WIDTH  port A read data.
b_enable_in, b_wb_in, b_be_in, b_addr_in, b_data_in, b_data_out  same widths and meanings as the port A signals, for port B.
ready_out  out  1  high when the clear sequence is done and accesses are accepted.
collision_out  out  1  one-cycle pulse on a same-address write collision.
collision_count_out  out  COUNT_WIDTH  saturating count of collisions.

Behaviour:
- Reset sampled high sets:
  - state = CLEAR, clear pointer = 0;
  - ready_out = 0, collision_out = 0, collision_count_out = 0;
  - both registered data_out = 0.
- Reset asserted mid-clear restarts the clear from address 0.
- FSM, state CLEAR:
  - Each edge writes 0 to mem[clear pointer] and increments the pointer.
  - On the edge that writes address SIZE-1, go to READY.
  - With reset released after edge k, addresses 0..SIZE-1 are written at edges k+1..k+SIZE.
  - ready_out is high after edge k+SIZE.
  - All port requests are ignored in CLEAR: no writes, collision logic idle, data_out = 0.
- FSM, state READY: only reset leaves READY.
- Write: in READY, at the edge with enable=1 and wb=1, each byte i with be[i]=1 updates; bytes with be[i]=0 keep their value. be=0 is a no-op write.
- Read, READ_LATENCY=0:
  - data_out = mem[addr] combinationally (pre-edge contents), regardless of enable.
  - Returns 0 in CLEAR.
- Read, READ_LATENCY=1:
  - On each edge with enable=1 (read or write), data_out is loaded and is valid the next cycle.
  - With enable=0, data_out holds.
  - Same-port write with RDW_MODE=0: loads the old word.
  - Same-port write with RDW_MODE=1: loads the old word with the enabled bytes replaced by data_in.
- Cross-port same-address read/write in the same cycle: the reader always gets the old word.
- Collision: both ports enabled and writing to the same in-range address in the same edge.
  - Per byte, port A wins where both be bits are set.
  - Bytes enabled only by B take B's data.
  - collision_out = 1 for the following cycle.
  - collision_count_out increments, saturating at 2^COUNT_WIDTH-1.
  - Two reads, or a read plus a write, to the same address are not collisions.
- Out of range (addr >= SIZE): the write is dropped, the read returns 0, and it is never a collision.
- Both ports may access different addresses in the same cycle with no interaction.

Test Plan:
1. SIZE=16: pulse reset for 1 cycle -> ready_out low for exactly 16 edges, then high. Pre-load garbage via backdoor before reset -> every address reads 0. Port A write to addr 3 during CLEAR -> addr 3 still reads 0.
2. Byte enables: write 0xAABBCCDD to addr 5, then write 0x11223344 with be=4'b0101 -> read addr 5 = 0xAA22CC44 one cycle after the request (READ_LATENCY=1).
3. Collision: A writes 0x11111111 with be=4'b0011 and B writes 0x22222222 with be=4'b1110, both to addr 7, same edge -> mem[7] = 0x22221111; collision_out pulses 1 cycle; count = 1. Repeat with COUNT_WIDTH=2 five times -> count saturates at 3.
4. Read-during-write, addr 9 holding 0x0: same-port write of 0xCAFEBABE with RDW_MODE=0 -> data_out 0x00000000; with RDW_MODE=1 -> 0xCAFEBABE. Port B reading addr 9 on the same edge -> 0x00000000 in both modes.
5. READ_LATENCY=0, SIZE=12: read addr 4 after a write -> value visible in the same cycle as the request. Write to addr 13 -> dropped, read of addr 13 returns 0, no collision even if both ports write it.
6. Reset asserted for 1 cycle midway through CLEAR (SIZE=16, at clear pointer 8) -> ready_out rises exactly 16 edges after the second reset is released.
